// File: rtl/exu_mul_wb_ctl.sv
// Writeback buffer behind the 3-stage multiplier: in-order FIFO of {rd, tag, data}
// feeding the register-file writeback arbiter via valid/ready, with flush and overflow.
module exu_mul_wb_ctl #(
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned TAG_W        = 4,
   parameter int unsigned AFULL_MARGIN = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       freeze,
   input  logic                       e3_valid,
   input  logic                       e3_kill,
   input  logic [4:0]                 e3_rd,
   input  logic [TAG_W-1:0]           e3_tag,
   input  logic [31:0]                e3_result,
   input  logic                       e4_flush,
   input  logic                       wb_ready,
   output logic                       wb_valid,
   output logic [4:0]                 wb_rd,
   output logic [TAG_W-1:0]           wb_tag,
   output logic [31:0]                wb_data,
   output logic                       almost_full,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_LVL  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AFULL_LVL = CNT_W'(DEPTH - AFULL_MARGIN);

   logic [4:0]       mem_rd   [DEPTH];
   logic [TAG_W-1:0] mem_tag  [DEPTH];
   logic [31:0]      mem_data [DEPTH];

   logic [PTR_W-1:0] wptr_q, rptr_q;
   logic [CNT_W-1:0] count_q;
   logic             overflow_q;

   logic push_req, pop, full, push, drop;

   always_comb begin
      push_req = e3_valid & ~e3_kill & ~freeze & ~e4_flush & (e3_rd != 5'd0);
      pop      = (count_q != '0) & wb_ready & ~e4_flush;
      full     = (count_q == FULL_LVL);
      // A full FIFO still accepts a push when the head retires in the same cycle.
      push     = push_req & (~full | pop);
      drop     = push_req & full & ~pop;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_rd[i]   <= '0;
            mem_tag[i]  <= '0;
            mem_data[i] <= '0;
         end
      end else if (e4_flush) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            mem_rd[wptr_q]   <= e3_rd;
            mem_tag[wptr_q]  <= e3_tag;
            mem_data[wptr_q] <= e3_result;
            wptr_q           <= wptr_q + PTR_W'(1);
         end
         if (pop) begin
            rptr_q <= rptr_q + PTR_W'(1);
         end
         count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
         if (drop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   always_comb begin
      wb_valid    = (count_q != '0);
      wb_rd       = mem_rd[rptr_q];
      wb_tag      = mem_tag[rptr_q];
      wb_data     = mem_data[rptr_q];
      almost_full = (count_q >= AFULL_LVL);
      count       = count_q;
      overflow    = overflow_q;
   end

endmodule
